// File: rtl/swipe_photo_ctrl.sv
// Photo index controller driven by the touch-motion swipe code.
// A swipe steps the index once, then locks out and waits for release; optional slideshow auto-advance.
module swipe_photo_ctrl #(
    parameter int NUM_PHOTOS = 8,
    parameter int IDX_W      = 3,
    parameter int LOCK_TICKS = 5,
    parameter int AUTO_TICKS = 50
) (
    input  logic             iRST_n,
    input  logic             clk_10Hz,
    input  logic [1:0]       iOut_count,
    input  logic             iAuto_en,
    output logic [IDX_W-1:0] oPhoto_idx,
    output logic             oIdx_pulse,
    output logic             oDir,
    output logic             oAuto,
    output logic             oBusy
);

    typedef enum logic [1:0] {IDLE, LOCKOUT, WAIT_REL} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PHOTOS - 1);
    localparam logic [7:0]       LOCK_INIT = 8'(LOCK_TICKS - 1);
    localparam logic [7:0]       AUTO_LAST = 8'(AUTO_TICKS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pulse_q, pulse_d;
    logic             dir_q, dir_d;
    logic             auto_q, auto_d;
    logic             busy_q, busy_d;
    logic [7:0]       lock_cnt_q, lock_cnt_d;
    logic [7:0]       auto_cnt_q, auto_cnt_d;

    logic swipe, go_next;
    logic [IDX_W-1:0] idx_inc, idx_dec;

    assign swipe   = (iOut_count == 2'b10) || (iOut_count == 2'b01);
    assign go_next = (iOut_count == 2'b10);
    assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign idx_dec = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pulse_d    = 1'b0;
        dir_d      = dir_q;
        auto_d     = 1'b0;
        lock_cnt_d = lock_cnt_q;
        auto_cnt_d = '0;
        case (state_q)
            IDLE: begin
                // A swipe takes priority over a simultaneous slideshow terminal count.
                if (swipe) begin
                    idx_d      = go_next ? idx_inc : idx_dec;
                    pulse_d    = 1'b1;
                    dir_d      = go_next;
                    lock_cnt_d = LOCK_INIT;
                    state_d    = LOCKOUT;
                end else if (iAuto_en) begin
                    if (auto_cnt_q == AUTO_LAST) begin
                        idx_d   = idx_inc;
                        pulse_d = 1'b1;
                        auto_d  = 1'b1;
                        dir_d   = 1'b1;
                    end else begin
                        auto_cnt_d = auto_cnt_q + 8'd1;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q != '0) lock_cnt_d = lock_cnt_q - 8'd1;
                else                  state_d    = WAIT_REL;
            end
            WAIT_REL: begin
                if (!swipe) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_10Hz or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pulse_q    <= 1'b0;
            dir_q      <= 1'b0;
            auto_q     <= 1'b0;
            busy_q     <= 1'b0;
            lock_cnt_q <= '0;
            auto_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
            dir_q      <= dir_d;
            auto_q     <= auto_d;
            busy_q     <= busy_d;
            lock_cnt_q <= lock_cnt_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign oPhoto_idx = idx_q;
    assign oIdx_pulse = pulse_q;
    assign oDir       = dir_q;
    assign oAuto      = auto_q;
    assign oBusy      = busy_q;

endmodule

// File: tb/tb_swipe_photo_ctrl.sv
// Randomized bench for swipe_photo_ctrl against a cycle-count reference model.
module tb_swipe_photo_ctrl;
    localparam int N = 8;
    localparam int L = 5;
    localparam int A = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] code;
    logic       auto_en;
    logic [2:0] photo_idx;
    logic       idx_pulse, dir, auto_o, busy;

    always #5 clk = ~clk;

    swipe_photo_ctrl #(.NUM_PHOTOS(N), .IDX_W(3), .LOCK_TICKS(L), .AUTO_TICKS(A)) dut (
        .iRST_n    (rst_n),
        .clk_10Hz  (clk),
        .iOut_count(code),
        .iAuto_en  (auto_en),
        .oPhoto_idx(photo_idx),
        .oIdx_pulse(idx_pulse),
        .oDir      (dir),
        .oAuto     (auto_o),
        .oBusy     (busy)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: busy tracked as edges elapsed since the accepted swipe,
    // slideshow as a run length of qualifying idle edges.
    int m_idx, m_dir, m_pulse, m_auto, m_busy, since, run;

    task automatic model_reset();
        m_idx = 0; m_dir = 0; m_pulse = 0; m_auto = 0; m_busy = 0; since = 0; run = 0;
    endtask

    task automatic model_step();
        bit sw;
        sw = (code == 2'b10) || (code == 2'b01);
        m_pulse = 0;
        m_auto  = 0;
        if (m_busy != 0) begin
            since++;
            run = 0;
            // L edges of lockout, one to enter release wait, then release on a non-swipe code
            if (since > L && !sw) m_busy = 0;
        end else if (sw) begin
            m_idx   = (code == 2'b10) ? (m_idx + 1) % N : (m_idx + N - 1) % N;
            m_dir   = (code == 2'b10);
            m_pulse = 1;
            m_busy  = 1;
            since   = 0;
            run     = 0;
        end else if (!auto_en) begin
            run = 0;
        end else begin
            run++;
            if (run == A) begin
                m_idx = (m_idx + 1) % N; m_pulse = 1; m_auto = 1; m_dir = 1; run = 0;
            end
        end
    endtask

    task automatic compare();
        chk("idx",   32'(photo_idx), 32'(m_idx));
        chk("pulse", 32'(idx_pulse), 32'(m_pulse));
        chk("dir",   32'(dir),       32'(m_dir));
        chk("auto",  32'(auto_o),    32'(m_auto));
        chk("busy",  32'(busy),      32'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic [1:0] c, input logic a, input int n);
        code = c;
        auto_en = a;
        repeat (n) tick();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rst_idx",  32'(photo_idx), 32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_puls", 32'(idx_pulse), 32'd0);
        code = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c, len;
        rst_n = 1'b0; code = 2'b00; auto_en = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_idx",  32'(photo_idx), 32'd0);
        chk("reset_dir",  32'(dir),       32'd0);
        chk("reset_busy", 32'(busy),      32'd0);
        chk("reset_auto", 32'(auto_o),    32'd0);
        rst_n = 1'b1;

        // single next swipe, lockout and release timing
        drive(2'b10, 1'b0, 1);
        chk("t1_idx",   32'(photo_idx), 32'd1);
        chk("t1_pulse", 32'(idx_pulse), 32'd1);
        chk("t1_dir",   32'(dir),       32'd1);
        chk("t1_busy",  32'(busy),      32'd1);
        drive(2'b00, 1'b0, 4);
        chk("t1_busy4", 32'(busy), 32'd1);
        drive(2'b00, 1'b0, 1);
        chk("t1_busy5", 32'(busy), 32'd1);
        drive(2'b00, 1'b0, 1);
        chk("t1_idle",  32'(busy), 32'd0);
        drive(2'b00, 1'b0, 3);

        // walk to 7, then wrap both ways
        repeat (6) begin drive(2'b10, 1'b0, 1); drive(2'b00, 1'b0, 7); end
        chk("t2_at7", 32'(photo_idx), 32'd7);
        drive(2'b10, 1'b0, 1);
        chk("t2_wrap_up", 32'(photo_idx), 32'd0);
        drive(2'b00, 1'b0, 7);
        drive(2'b01, 1'b0, 1);
        chk("t2_wrap_dn", 32'(photo_idx), 32'd7);
        chk("t2_dir",     32'(dir),       32'd0);
        drive(2'b00, 1'b0, 7);

        // held swipe steps only once; busy until release
        drive(2'b10, 1'b0, 20);
        chk("t3_idx",  32'(photo_idx), 32'd0);
        chk("t3_busy", 32'(busy),      32'd1);
        drive(2'b00, 1'b0, 1);
        chk("t3_rel",  32'(busy),      32'd0);

        // code 11 is not a swipe
        drive(2'b11, 1'b0, 10);
        chk("t4_idx", 32'(photo_idx), 32'd0);

        // slideshow, then swipe colliding with terminal count
        drive(2'b00, 1'b1, 49);
        chk("t5_pre",  32'(idx_pulse), 32'd0);
        drive(2'b00, 1'b1, 1);
        chk("t5_auto", 32'(auto_o),    32'd1);
        chk("t5_idx",  32'(photo_idx), 32'd1);
        drive(2'b00, 1'b1, 49);
        drive(2'b01, 1'b1, 1);
        chk("t5_sw_auto", 32'(auto_o),    32'd0);
        chk("t5_sw_idx",  32'(photo_idx), 32'd0);
        drive(2'b00, 1'b1, 60);

        // asynchronous reset mid-lockout
        drive(2'b10, 1'b0, 1);
        drive(2'b00, 1'b0, 2);
        async_reset();
        drive(2'b00, 1'b0, 2);
        drive(2'b10, 1'b0, 1);
        chk("t6_idx", 32'(photo_idx), 32'd1);
        drive(2'b00, 1'b0, 7);

        // random segments
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) async_reset();
            if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
            c = $urandom_range(0, 7);
            if (c < 5) begin code = 2'b00; len = $urandom_range(1, 70); end
            else begin code = 2'(c - 4); len = $urandom_range(1, 20); end
            drive(code, auto_en, len);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
